unit_share_arbiter: RTL and testbench



---
 rtl/unit_share_pkg.sv | 51 +++++
 rtl/unit_share_arbiter_rr_arbiter.sv | 70 +++++++
 rtl/unit_share_arbiter.sv | 132 +++++++++++++
 tb/tb_unit_share_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/unit_share_pkg.sv
// -----------------------------------------------------------------------------
// unit_share_pkg
// Shared types and helpers for the unit-sharing arbiter slice.
//   word_t  : signed operand/result word handled by the shared compute unit
//   tag_t   : one tag-pipeline stage, {valid, requester id}
//   pick_t  : result of a round-robin search, {found, index}
//   rr_pick : round-robin search over a request vector starting at a pointer
// Widths are sized for the largest supported requester count (16), so the
// id/index fields are always 4 bits. Modules with fewer requesters use the
// low bits only.
// -----------------------------------------------------------------------------
package unit_share_pkg;

    localparam int WORD_W  = 32;
    localparam int MAX_N   = 16;
    localparam int MAX_IDW = 4;

    typedef logic signed [WORD_W-1:0] word_t;

    typedef struct packed {
        logic               v;
        logic [MAX_IDW-1:0] id;
    } tag_t;

    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] idx;
    } pick_t;

    // Scan valid[] starting at ptr and wrapping modulo n; the first set bit
    // wins. The loop runs over the maximum size so it elaborates to a fixed
    // priority structure, with positions beyond n simply disabled.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0]   valid,
                                      input logic [MAX_IDW-1:0] ptr,
                                      input int                 n);
        pick_t result;
        int    j;
        result = '0;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                j = (int'(ptr) + k) % n;
                if (!result.found && valid[j[MAX_IDW-1:0]]) begin
                    result.found = 1'b1;
                    result.idx   = j[MAX_IDW-1:0];
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/unit_share_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter that owns the search pointer.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   req      : per-requester request vector
//   advance  : a grant was actually taken this cycle; moves the pointer
//   gnt      : one-hot grant (or zero), combinational from req and pointer
//   gnt_idx  : binary index of the granted requester (only meaningful with gnt)
// -----------------------------------------------------------------------------
module rr_arbiter
    import unit_share_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     ptr_next;
    logic [MAX_N-1:0]   req_ext;
    logic [MAX_IDW-1:0] ptr_ext;
    pick_t              pick;

    // Widen the request vector and pointer to the package's fixed search width
    // and run the round-robin search. The grant is forced to zero while reset
    // is asserted so nothing can be accepted during reset.
    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req;
        ptr_ext          = '0;
        ptr_ext[IDW-1:0] = ptr;
        pick             = rr_pick(req_ext, ptr_ext, N);
        gnt              = '0;
        gnt_idx          = pick.idx[IDW-1:0];
        if (pick.found && !rst) begin
            gnt[pick.idx[IDW-1:0]] = 1'b1;
        end
    end

    // The pointer moves to the requester just after the winner, wrapping from
    // the last requester back to zero. An explicit compare handles requester
    // counts that are not a power of two. With one requester this always
    // yields zero.
    always_comb begin
        if (int'(pick.idx) >= N - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = pick.idx[IDW-1:0] + IDW'(1);
        end
    end

    // The pointer only moves when a grant was consumed. Otherwise it holds, so
    // a requester that drops its request without being served does not disturb
    // the fairness order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/unit_share_arbiter.sv
// -----------------------------------------------------------------------------
// unit_share_arbiter
// Shares one fixed-latency compute unit between N requesters. Requests are
// granted round-robin, one operand is issued per cycle, and the id of each
// in-flight operand travels down a tag pipeline. Each result is then steered
// back to the requester that issued it.
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   req_valid   : per-requester request valid
//   req_data    : per-requester operands, slice i at [i*W +: W]
//   req_ready   : one-hot (or zero) accept, combinational
//   unit_a      : registered operand to the shared unit
//   unit_valid  : unit_a carries a live operand this cycle
//   unit_b      : unit result, LAT cycles after the matching unit_valid
//   rsp_valid   : one-hot result strobe, no backpressure
//   rsp_data    : result payload shared by all requesters (zero when idle)
//   busy        : any operation still in flight
// -----------------------------------------------------------------------------
module unit_share_arbiter
    import unit_share_pkg::*;
#(
    parameter int N   = 4,
    parameter int LAT = 2,
    parameter int W   = 32,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic [W-1:0]   unit_a,
    output logic           unit_valid,
    input  logic [W-1:0]   unit_b,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_data,
    output logic           busy
);

    logic           transfer;
    logic [IDW-1:0] gnt_idx;
    logic [W-1:0]   grant_data;
    logic [IDW-1:0] unit_id;
    tag_t           tag_in;
    tag_t           tags [LAT];
    tag_t           aligned;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (transfer),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    // The grant is one-hot, so the winner's operand is selected with an
    // AND-OR over the one-hot vector rather than a variable part select.
    always_comb begin
        transfer   = |(req_valid & req_ready);
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                grant_data = req_data[i*W +: W];
            end
        end
    end

    // Issue register. The operand and its requester id are captured together
    // on an accept. unit_a keeps its old value on idle cycles because only
    // unit_valid qualifies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_valid <= 1'b0;
            unit_a     <= '0;
            unit_id    <= '0;
        end else begin
            unit_valid <= transfer;
            if (transfer) begin
                unit_a  <= grant_data;
                unit_id <= gnt_idx;
            end
        end
    end

    // Stage 0 samples the issue register, not the raw grant. The unit's LAT
    // cycles start when it sees unit_a, so the last stage then lines up
    // exactly with unit_b.
    always_comb begin
        tag_in              = '0;
        tag_in.v            = unit_valid;
        tag_in.id[IDW-1:0]  = unit_id;
    end

    // Tag pipeline: shifts every cycle unconditionally. Reset clears every
    // stage, so results already inside the unit are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= tag_in;
            for (int i = 1; i < LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    // Response steering is combinational from unit_b. The payload is zeroed
    // when the aligned tag is empty so garbage on unit_b never escapes.
    always_comb begin
        aligned   = tags[LAT-1];
        rsp_valid = '0;
        rsp_data  = '0;
        if (aligned.v) begin
            rsp_valid[aligned.id[IDW-1:0]] = 1'b1;
            rsp_data                       = unit_b;
        end
    end

    // Busy covers the issue register and every tag stage.
    always_comb begin
        busy = unit_valid;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | tags[i].v;
        end
    end

endmodule

// File: tb/tb_unit_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unit_share_arbiter
// Directed and random stimulus for unit_share_arbiter with N=4 and LAT=2.
// The bench models the shared unit as b = a + 7. It predicts grants,
// issue-register contents, responses and busy from a queue of outstanding
// operations, each with the cycle in which its result is due.
// -----------------------------------------------------------------------------
module tb_unit_share_arbiter;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int W   = 32;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   unit_a;
    logic           unit_valid;
    logic [W-1:0]   unit_b;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;

    unit_share_arbiter #(
        .N   (N),
        .LAT (LAT),
        .W   (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .unit_a     (unit_a),
        .unit_valid (unit_valid),
        .unit_b     (unit_b),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared compute unit: b = a + 7, LAT cycles after a is
    // sampled.
    logic [W-1:0] env_pipe [LAT];
    always @(posedge clk) begin
        env_pipe[0] <= unit_a + 32'd7;
        for (int i = 1; i < LAT; i++) begin
            env_pipe[i] <= env_pipe[i-1];
        end
    end
    assign unit_b = env_pipe[LAT-1];

    // Reference model state.
    typedef struct {
        int           id;
        logic [W-1:0] val;
        int           due;
    } exp_t;

    exp_t         exp_q [$];
    int           m_ptr;
    int           cyc;
    logic         m_uv;
    logic [W-1:0] m_ua;
    int           pass_cnt;
    int           check_cnt;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic modelReset();
        exp_q.delete();
        m_ptr = 0;
        m_uv  = 1'b0;
        m_ua  = '0;
    endtask

    // One clock cycle: drive the inputs just after the edge, check all outputs
    // at the falling edge, then advance the model at the rising edge.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] d);
        int           g;
        logic [N-1:0] exp_rv;
        logic [W-1:0] exp_rd;
        logic [W-1:0] op;
        req_valid = v;
        req_data  = d;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        exp_rv = '0;
        exp_rd = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_rv[exp_q[0].id] = 1'b1;
            exp_rd              = exp_q[0].val;
        end
        @(negedge clk);
        checkOutput("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'(0));
        checkOutput("unit_valid", 64'(unit_valid), 64'(m_uv));
        checkOutput("unit_a", 64'(unit_a), 64'(m_ua));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        checkOutput("rsp_data", 64'(rsp_data), 64'(exp_rd));
        checkOutput("busy", 64'(busy), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
        @(posedge clk);
        if (g >= 0) begin
            op = d[g*W +: W];
            exp_q.push_back('{id: g, val: op + 32'd7, due: cyc + 1 + LAT});
            m_uv  = 1'b1;
            m_ua  = op;
            m_ptr = (g + 1) % N;
        end else begin
            m_uv = 1'b0;
        end
        cyc++;
        #1;
    endtask

    function automatic logic [N*W-1:0] randData();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
        return d;
    endfunction

    logic [N*W-1:0] dvec;

    initial begin
        pass_cnt  = 0;
        check_cnt = 0;
        cyc       = 0;
        modelReset();
        rst       = 1'b1;
        req_valid = 4'b0010;
        req_data  = randData();
        #1;
        checkOutput("reset_req_ready", 64'(req_ready), 64'(0));
        checkOutput("reset_unit_valid", 64'(unit_valid), 64'(0));
        checkOutput("reset_unit_a", 64'(unit_a), 64'(0));
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("reset_rsp_data", 64'(rsp_data), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single request from requester 1");
        dvec = randData();
        dvec[1*W +: W] = 32'd5;
        applyStimulus(4'b0010, dvec);
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, randData());

        $display("[TB] round-robin fairness, all requesters valid");
        for (int i = 0; i < 8; i++) applyStimulus(4'b1111, randData());
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, randData());

        $display("[TB] pointer wrap 3 -> 0");
        applyStimulus(4'b1000, randData());
        applyStimulus(4'b1001, randData());
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, randData());

        $display("[TB] sustained single requester");
        for (int i = 1; i <= 5; i++) begin
            dvec = randData();
            dvec[2*W +: W] = 32'(i);
            applyStimulus(4'b0100, dvec);
        end
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, randData());

        $display("[TB] idle gaps");
        applyStimulus(4'b1000, randData());
        applyStimulus(4'b0000, randData());
        applyStimulus(4'b0100, randData());
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, randData());

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), randData());
        end
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, randData());

        $display("[TB] reset mid-flight");
        applyStimulus(4'b0110, randData());
        applyStimulus(4'b0110, randData());
        req_valid = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("flush_busy", 64'(busy), 64'(0));
        checkOutput("flush_unit_valid", 64'(unit_valid), 64'(0));
        checkOutput("flush_unit_a", 64'(unit_a), 64'(0));
        checkOutput("flush_req_ready", 64'(req_ready), 64'(0));
        checkOutput("flush_rsp_valid", 64'(rsp_valid), 64'(0));
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, randData());
        applyStimulus(4'b1111, randData());
        applyStimulus(4'b1111, randData());
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, randData());

        checkOutput("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
